// File: rtl/bsg_link_pkg.sv
// Shared definitions for the BSG narrow link: io/core widths, the halfword
// that one flow-control credit stands for, and the transmitter byte-slot
// naming used by the link models and monitors.
package bsg_link_pkg;

  localparam int LINK_IO_W   = 8;
  // One credit is one 16-bit receiver buffer entry, which is two io bytes.
  localparam int LINK_HALF_W = 2 * LINK_IO_W;
  localparam int LINK_CORE_W = 2 * LINK_HALF_W;

  // B0..B3 name the byte slot of the held word currently on the link.
  typedef enum logic [2:0] {
    TX_IDLE = 3'd0,
    TX_B0   = 3'd1,
    TX_B1   = 3'd2,
    TX_B2   = 3'd3,
    TX_B3   = 3'd4
  } tx_state_e;

  // First byte of a halfword; emitting it claims a receiver credit.
  function automatic logic is_halfword_start(input tx_state_e s);
    return (s == TX_B0) || (s == TX_B2);
  endfunction

endpackage

// File: rtl/bsg_link_credit_counter.sv
// Up/down credit counter. Starts full, saturates at MAX, and latches a
// sticky overflow flag if an increment arrives while already full.
module bsg_link_credit_counter #(
  parameter  int MAX   = 64,
  localparam int CNT_W = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_o
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX);

  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  // Next count: simultaneous inc/dec cancel; full+inc saturates and flags.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (inc_i && !dec_i) begin
      if (count_q == FULL) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count and sticky overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= FULL;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/bsg_upstream_tx.sv
// Transmit end of the BSG narrow link: takes 32-bit core words and sends
// them as four io bytes, low byte of each halfword first, gated by
// halfword credits returned from the receiver.
//
// state   | meaning
// --------+-----------------------------------------------------------
// TX_IDLE | no word held; ready for a core word
// TX_B0   | byte [7:0] pending; needs a credit, stalls at zero credits
// TX_B1   | byte [15:8] on the link (halfword 0 already paid for)
// TX_B2   | byte [23:16] pending; needs a credit, stalls at zero
// TX_B3   | byte [31:24] on the link; may accept the next word
module bsg_upstream_tx
  import bsg_link_pkg::*;
#(
  parameter  int CORE_W  = LINK_CORE_W,
  parameter  int IO_W    = LINK_IO_W,
  parameter  int CREDITS = 64,
  localparam int CNT_W   = $clog2(CREDITS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_valid_in,
  input  logic [CORE_W-1:0] core_data_in,
  output logic              core_ready_out,
  output logic              io_valid_out,
  output logic [IO_W-1:0]   io_data_out,
  input  logic              io_token_in,
  output logic [CNT_W-1:0]  credits_avail,
  output logic              err_credit_ovf
);

  tx_state_e         state_q, state_d;
  logic [CORE_W-1:0] hold_q, hold_d;
  logic              accept;
  logic              consume;
  logic [CNT_W-1:0]  credits;

  bsg_link_credit_counter #(
    .MAX(CREDITS)
  ) u_credit_counter (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (io_token_in),
    .dec_i   (consume),
    .count_o (credits),
    .ovf_o   (err_credit_ovf)
  );

  assign credits_avail = credits;

  // Handshake, byte selection, credit consumption and next state.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    io_data_out = '0;

    // Taking the next word in B3 lets words stream with no idle cycle.
    core_ready_out = (state_q == TX_IDLE) || (state_q == TX_B3);
    accept         = core_valid_in && core_ready_out;

    // A halfword only starts when the receiver has room for all of it.
    io_valid_out = (state_q != TX_IDLE) &&
                   (!is_halfword_start(state_q) || (credits != '0));
    consume      = io_valid_out && is_halfword_start(state_q);

    // During a stall the pending byte stays on the data lines.
    case (state_q)
      TX_B0:   io_data_out = hold_q[IO_W-1:0];
      TX_B1:   io_data_out = hold_q[2*IO_W-1:IO_W];
      TX_B2:   io_data_out = hold_q[3*IO_W-1:2*IO_W];
      TX_B3:   io_data_out = hold_q[4*IO_W-1:3*IO_W];
      default: io_data_out = '0;
    endcase

    case (state_q)
      TX_IDLE: if (accept) state_d = TX_B0;
      TX_B0:   if (io_valid_out) state_d = TX_B1;
      TX_B1:   state_d = TX_B2;
      TX_B2:   if (io_valid_out) state_d = TX_B3;
      TX_B3:   state_d = accept ? TX_B0 : TX_IDLE;
      default: state_d = TX_IDLE;
    endcase

    if (accept) hold_d = core_data_in;
  end

  // State and held-word registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_bsg_upstream_tx.sv
module tb_bsg_upstream_tx;

  localparam int CREDITS = 64;
  localparam int CNT_W   = $clog2(CREDITS + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             core_valid_in = 1'b0;
  logic [31:0]      core_data_in = '0;
  logic             core_ready_out;
  logic             io_valid_out;
  logic [7:0]       io_data_out;
  logic             io_token_in = 1'b0;
  logic [CNT_W-1:0] credits_avail;
  logic             err_credit_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bsg_upstream_tx #(
    .CORE_W (32),
    .IO_W   (8),
    .CREDITS(CREDITS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .core_valid_in (core_valid_in),
    .core_data_in  (core_data_in),
    .core_ready_out(core_ready_out),
    .io_valid_out  (io_valid_out),
    .io_data_out   (io_data_out),
    .io_token_in   (io_token_in),
    .credits_avail (credits_avail),
    .err_credit_ovf(err_credit_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    core_valid_in = 1'b0;
    core_data_in  = '0;
    io_token_in   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Streams n random words back to back and returns to idle.
  task automatic send_words(input int n);
    for (int i = 0; i < n; i++) begin
      core_data_in  = $urandom;
      core_valid_in = 1'b1;
      repeat (4) tick();
    end
    core_valid_in = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (core_ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", core_ready_out); end
    total++; if (io_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", io_valid_out); end
    total++; if (io_data_out !== 8'h00) begin bad++; $display("FAIL reset_data got %h want 00", io_data_out); end
    total++; if (credits_avail !== CNT_W'(CREDITS)) begin bad++; $display("FAIL reset_credits got %0d want %0d", credits_avail, CREDITS); end
    total++; if (err_credit_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got %b want 0", err_credit_ovf); end
  endtask

  task automatic test_single_word();
    logic [31:0] w;
    w = 32'hDDCCBBAA;
    do_reset();
    core_data_in  = w;
    core_valid_in = 1'b1;
    tick();
    core_valid_in = 1'b0;
    core_data_in  = 32'h12345678;
    for (int k = 0; k < 4; k++) begin
      total++; if (io_valid_out !== 1'b1) begin bad++; $display("FAIL single_valid[%0d] got %b want 1", k, io_valid_out); end
      total++; if (io_data_out !== w[8*k +: 8]) begin bad++; $display("FAIL single_data[%0d] got %h want %h", k, io_data_out, w[8*k +: 8]); end
      tick();
    end
    total++; if (io_valid_out !== 1'b0) begin bad++; $display("FAIL single_after_valid got %b want 0", io_valid_out); end
    total++; if (credits_avail !== CNT_W'(62)) begin bad++; $display("FAIL single_credits got %0d want 62", credits_avail); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    core_data_in  = 32'h03020100;
    core_valid_in = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      total++; if (io_valid_out !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got %b want 1", k, io_valid_out); end
      total++; if (io_data_out !== 8'(k)) begin bad++; $display("FAIL b2b_data[%0d] got %h want %h", k, io_data_out, 8'(k)); end
      total++; if (core_ready_out !== ((k % 4) == 3)) begin bad++; $display("FAIL b2b_ready[%0d] got %b want %b", k, core_ready_out, ((k % 4) == 3)); end
      if (k == 3) core_data_in = 32'h07060504;
      if (k == 7) core_valid_in = 1'b0;
      tick();
    end
    total++; if (io_valid_out !== 1'b0) begin bad++; $display("FAIL b2b_idle_valid got %b want 0", io_valid_out); end
    total++; if (core_ready_out !== 1'b1) begin bad++; $display("FAIL b2b_idle_ready got %b want 1", core_ready_out); end
    total++; if (credits_avail !== CNT_W'(60)) begin bad++; $display("FAIL b2b_credits got %0d want 60", credits_avail); end
  endtask

  task automatic test_stall();
    do_reset();
    send_words(32);
    total++; if (credits_avail !== CNT_W'(0)) begin bad++; $display("FAIL stall_drained got %0d want 0", credits_avail); end
    io_token_in = 1'b1;
    tick();
    io_token_in = 1'b0;
    total++; if (credits_avail !== CNT_W'(1)) begin bad++; $display("FAIL stall_one_credit got %0d want 1", credits_avail); end
    core_data_in  = 32'hDDCCBBAA;
    core_valid_in = 1'b1;
    tick();
    core_valid_in = 1'b0;
    total++; if (io_valid_out !== 1'b1 || io_data_out !== 8'hAA) begin bad++; $display("FAIL stall_b0 got v=%b d=%h want v=1 d=aa", io_valid_out, io_data_out); end
    tick();
    total++; if (io_valid_out !== 1'b1 || io_data_out !== 8'hBB) begin bad++; $display("FAIL stall_b1 got v=%b d=%h want v=1 d=bb", io_valid_out, io_data_out); end
    tick();
    for (int s = 0; s < 4; s++) begin
      total++; if (io_valid_out !== 1'b0) begin bad++; $display("FAIL stall_hold_valid[%0d] got %b want 0", s, io_valid_out); end
      total++; if (core_ready_out !== 1'b0) begin bad++; $display("FAIL stall_hold_ready[%0d] got %b want 0", s, core_ready_out); end
      if (s < 3) begin
        core_valid_in = 1'b1;
        core_data_in  = $urandom;
      end else begin
        core_valid_in = 1'b0;
        io_token_in   = 1'b1;
      end
      tick();
      io_token_in = 1'b0;
    end
    total++; if (io_valid_out !== 1'b1 || io_data_out !== 8'hCC) begin bad++; $display("FAIL stall_resume_b2 got v=%b d=%h want v=1 d=cc", io_valid_out, io_data_out); end
    tick();
    total++; if (io_valid_out !== 1'b1 || io_data_out !== 8'hDD) begin bad++; $display("FAIL stall_resume_b3 got v=%b d=%h want v=1 d=dd", io_valid_out, io_data_out); end
    tick();
    total++; if (io_valid_out !== 1'b0) begin bad++; $display("FAIL stall_end_valid got %b want 0", io_valid_out); end
  endtask

  task automatic test_token_coincident();
    do_reset();
    send_words(30);
    io_token_in = 1'b1;
    tick();
    io_token_in = 1'b0;
    total++; if (credits_avail !== CNT_W'(5)) begin bad++; $display("FAIL coin_pre got %0d want 5", credits_avail); end
    core_data_in  = 32'h0BADF00D;
    core_valid_in = 1'b1;
    tick();
    core_valid_in = 1'b0;
    total++; if (io_valid_out !== 1'b1 || io_data_out !== 8'h0D) begin bad++; $display("FAIL coin_b0 got v=%b d=%h want v=1 d=0d", io_valid_out, io_data_out); end
    io_token_in = 1'b1;
    tick();
    io_token_in = 1'b0;
    total++; if (credits_avail !== CNT_W'(5)) begin bad++; $display("FAIL coin_same got %0d want 5", credits_avail); end
    tick();
    tick();
    total++; if (credits_avail !== CNT_W'(4)) begin bad++; $display("FAIL coin_after_b2 got %0d want 4", credits_avail); end
    tick();
  endtask

  task automatic test_overflow();
    do_reset();
    io_token_in = 1'b1;
    tick();
    io_token_in = 1'b0;
    total++; if (err_credit_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got %b want 1", err_credit_ovf); end
    total++; if (credits_avail !== CNT_W'(CREDITS)) begin bad++; $display("FAIL ovf_saturate got %0d want %0d", credits_avail, CREDITS); end
    send_words(1);
    repeat (3) tick();
    total++; if (err_credit_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got %b want 1", err_credit_ovf); end
    total++; if (credits_avail !== CNT_W'(62)) begin bad++; $display("FAIL ovf_credits_after got %0d want 62", credits_avail); end
    do_reset();
    total++; if (err_credit_ovf !== 1'b0) begin bad++; $display("FAIL ovf_cleared got %b want 0", err_credit_ovf); end
  endtask

  task automatic test_async_reset();
    logic [31:0] w;
    do_reset();
    core_data_in  = 32'h88776655;
    core_valid_in = 1'b1;
    tick();
    core_valid_in = 1'b0;
    tick();
    total++; if (io_valid_out !== 1'b1 || io_data_out !== 8'h66) begin bad++; $display("FAIL arst_pre_b1 got v=%b d=%h want v=1 d=66", io_valid_out, io_data_out); end
    #2 rst = 1'b1;
    #1;
    total++; if (io_valid_out !== 1'b0) begin bad++; $display("FAIL arst_valid got %b want 0", io_valid_out); end
    total++; if (credits_avail !== CNT_W'(CREDITS)) begin bad++; $display("FAIL arst_credits got %0d want %0d", credits_avail, CREDITS); end
    total++; if (core_ready_out !== 1'b1) begin bad++; $display("FAIL arst_ready got %b want 1", core_ready_out); end
    total++; if (io_data_out !== 8'h00) begin bad++; $display("FAIL arst_data got %h want 00", io_data_out); end
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (io_valid_out !== 1'b0) begin bad++; $display("FAIL arst_quiet[%0d] got %b want 0", i, io_valid_out); end
      tick();
    end
    w = 32'h44332211;
    core_data_in  = w;
    core_valid_in = 1'b1;
    tick();
    core_valid_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++; if (io_valid_out !== 1'b1 || io_data_out !== w[8*k +: 8]) begin bad++; $display("FAIL arst_word[%0d] got v=%b d=%h want v=1 d=%h", k, io_valid_out, io_data_out, w[8*k +: 8]); end
      tick();
    end
    total++; if (credits_avail !== CNT_W'(62)) begin bad++; $display("FAIL arst_word_credits got %0d want 62", credits_avail); end
  endtask

  // Reference: a byte queue filled four bytes (LSB first) per accepted word;
  // each halfword start costs one credit, tokens add one.
  task automatic test_random();
    logic [7:0] q[$];
    int         mcred;
    int         emitted;
    logic       exp_v;
    bit         driving;
    bit         drained;
    do_reset();
    mcred   = CREDITS;
    emitted = 0;
    drained = 1'b0;
    for (int c = 0; c < 900; c++) begin
      driving = (c < 600);
      if (!driving && q.size() == 0) begin
        drained = 1'b1;
        break;
      end
      total++; if (credits_avail !== CNT_W'(mcred)) begin bad++; $display("FAIL rand_credits cyc %0d got %0d want %0d", c, credits_avail, mcred); end
      exp_v = (q.size() > 0) && (((emitted % 2) == 1) || (mcred > 0));
      total++; if (io_valid_out !== exp_v) begin bad++; $display("FAIL rand_valid cyc %0d got %b want %b", c, io_valid_out, exp_v); end
      total++; if (core_ready_out !== (q.size() <= 1)) begin bad++; $display("FAIL rand_ready cyc %0d got %b want %b", c, core_ready_out, (q.size() <= 1)); end
      if (io_valid_out === 1'b1 && q.size() > 0) begin
        total++; if (io_data_out !== q[0]) begin bad++; $display("FAIL rand_data cyc %0d got %h want %h", c, io_data_out, q[0]); end
        void'(q.pop_front());
        if ((emitted % 2) == 0) mcred--;
        emitted++;
      end
      core_valid_in = driving && ($urandom_range(0, 3) != 0);
      core_data_in  = $urandom;
      io_token_in   = (mcred < CREDITS) && ($urandom_range(0, 3) == 0);
      if (io_token_in) mcred++;
      if (core_valid_in && core_ready_out) begin
        for (int k = 0; k < 4; k++) q.push_back(core_data_in[8*k +: 8]);
      end
      tick();
    end
    core_valid_in = 1'b0;
    io_token_in   = 1'b0;
    if (!drained) begin
      total++;
      bad++;
      $display("FAIL rand_drain_timeout pending %0d bytes want 0", q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_token_coincident();
    test_overflow();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
